// File: rtl/alu_seq.sv
// Sequential ALU: one-cycle logic/arith ops plus an
// iterative shift-add multiplier producing a 2*WIDTH product.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_NOT  = 4'b1100;
  localparam logic [3:0] OP_NOR  = 4'b1101;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_op;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_hi;
  logic               r_zero;
  logic               r_ovf;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH-1:0]   w_alu;
  logic               w_ovf;
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_pnext;

  assign w_sum  = r_a + r_b;
  assign w_diff = r_a - r_b;
  assign w_sh   = r_b[SHW-1:0];

  // Single-cycle operation result and signed overflow
  always_comb begin
    w_alu = '0;
    w_ovf = 1'b0;
    unique case (r_op)
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_NOR:  w_alu = ~(r_a | r_b);
      OP_NOT:  w_alu = ~r_a;
      OP_ADD: begin
        w_alu = w_sum;
        w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu = w_diff;
        w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, r_a < r_b};
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}},
                        $signed(r_a) < $signed(r_b)};
      OP_SLL:  w_alu = r_a << w_sh;
      OP_SRL:  w_alu = r_a >> w_sh;
      OP_SRA:  w_alu = $unsigned($signed(r_a) >>> w_sh);
      default: w_alu = '0;
    endcase
  end

  // One shift-add multiplier step: add multiplicand into
  // the upper half when the current multiplier bit is set
  always_comb begin
    w_madd  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
              {1'b0, (r_prod[0] ? r_a : '0)};
    w_pnext = {w_madd, r_prod[WIDTH-1:1]};
  end

  // Control FSM with registered result and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_res   <= '0;
      r_hi    <= '0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_op   <= ctrl;
            r_cnt  <= '0;
            r_prod <= {{WIDTH{1'b0}}, b};
            r_state <= (ctrl == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          r_res   <= w_alu;
          r_hi    <= '0;
          r_zero  <= (w_alu == '0);
          r_ovf   <= w_ovf;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        S_MUL: begin
          r_prod <= w_pnext;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_res   <= w_pnext[WIDTH-1:0];
            r_hi    <= w_pnext[2*WIDTH-1:WIDTH];
            r_zero  <= (w_pnext[WIDTH-1:0] == '0);
            r_ovf   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign result    = r_res;
  assign result_hi = r_hi;
  assign zero      = r_zero;
  assign ovf       = r_ovf;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 32, giving the operand and result width (legal range 8..64).
REQ-002 The block SHALL have the parameter SHW, default $clog2(WIDTH), giving the shift-amount width taken from b[SHW-1:0].
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have the port start, input, 1 bit: requests an operation on a, b and ctrl.
REQ-006 The block SHALL have the ports a and b, inputs, WIDTH bits each: the operands, sampled only on an accepted start.
REQ-007 The block SHALL have the port ctrl, input, 4 bits: the operation select, sampled only on an accepted start.
REQ-008 The block SHALL have the port busy, output, 1 bit: high while an operation is in flight.
REQ-009 The block SHALL have the port done, output, 1 bit: a one-cycle pulse when result is updated.
REQ-010 The block SHALL have the port result, output, WIDTH bits: registered result, held until the next done.
REQ-011 The block SHALL have the port result_hi, output, WIDTH bits: upper product half after a multiply, 0 after any other operation.
REQ-012 The block SHALL have the port zero, output, 1 bit: registered flag, result == 0.
REQ-013 The block SHALL have the port ovf, output, 1 bit: registered signed overflow for add and subtract, 0 for every other operation.

Function
REQ-014 ctrl encoding SHALL be:
- 0000 AND; 0001 OR; 0010 ADD; 0110 SUB
- 0111 unsigned less-than (result 1 or 0); 1100 NOT a
- 0100 XOR; 1101 NOR; 1011 signed less-than
- 1000 SLL; 1001 SRL; 1010 SRA
- 0011 unsigned MUL
- any other code: result 0
REQ-015 The FSM SHALL have the states IDLE, EXEC and MUL; start is accepted only in IDLE.
REQ-016 IDLE + start + ctrl != 0011 SHALL go to EXEC.
- The next edge writes result, zero and ovf, pulses done and returns to IDLE.
- Latency is 1 cycle from the accepting edge.
REQ-017 IDLE + start + ctrl == 0011 SHALL go to MUL.
- Iterative shift-add, one multiplier bit per cycle, for WIDTH cycles.
- On the final iteration edge: {result_hi, result} = a*b (2*WIDTH bits), done pulses, return to IDLE.
- Latency is WIDTH cycles from the accepting edge.
REQ-018 busy SHALL be high in EXEC and MUL and low in IDLE; done SHALL never be high in the same cycle as busy.
REQ-019 A start while busy SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-020 start may be asserted in the same cycle done is high; it SHALL be accepted, giving back-to-back operations with a one-cycle done gap.
REQ-021 ADD and SUB SHALL wrap modulo 2^WIDTH; ovf = operand signs match (for SUB, a and ~b) and the result sign differs.
REQ-022 Shift amount SHALL be b[SHW-1:0]; SRA replicates a[WIDTH-1]; a shift of 0 returns a.
REQ-023 For MUL, zero SHALL reflect result (the low half) only; ovf = 0.
REQ-024 Operands SHALL be captured at acceptance; changes to a, b or ctrl during busy SHALL NOT affect the result.

Reset
REQ-025 rst_n low at a clock edge SHALL force:
- state IDLE; busy, done, zero and ovf to 0
- result and result_hi to 0
REQ-026 Reset asserted mid-MUL or in EXEC SHALL abort the operation with no done pulse; the first start after release starts a fresh operation.
REQ-027 zero SHALL read 0 out of reset (not derived from the reset result) until the first done.

Verification
REQ-028 The bench SHALL cover the following scenarios (WIDTH=32 unless noted):
- ADD/ovf: a=0x7FFFFFFF, b=1, ctrl=0010, start -> next cycle done=1, result=0x80000000, ovf=1, zero=0.
- SUB/zero: a=5, b=5, ctrl=0110 -> result=0, zero=1, ovf=0; then ctrl=1011, a=0xFFFFFFFF, b=1 -> result=1.
- MUL: a=0xFFFFFFFF, b=2, ctrl=0011 -> busy for 32 cycles, done at accept+32, result=0xFFFFFFFE, result_hi=1; a start during busy is ignored.
- Shifts: a=0x80000000, b=0x24 (amount 4) -> SRA gives 0xF8000000, SRL gives 0x08000000, SLL gives 0.
- Reset abort: rst_n low at cycle 10 of a MUL -> busy=0, result=0, no done; a following ADD 2+3 -> result=5.
- Back-to-back: start held high with ADD then AND -> done every second cycle with correct results; a WIDTH=8 MUL 0xFF*0xFF -> {result_hi, result}=0xFE01.
